systolic_skew_feeder: RTL and testbench
=======================================

SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 1024, bit width of every matrix element and lane.
REQ-002 SHALL have parameter MATRIX_SIZE, default 3, matrix dimension N (N >= 2).
REQ-003 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request to stream one matrix pair.
REQ-006 SHALL have port mat_a, input, DATA_SIZE x N*N, matrix A row-major, index r*N+c.
REQ-007 SHALL have port mat_b, input, DATA_SIZE x N*N, matrix B row-major, index r*N+c.
REQ-008 SHALL have port out_a, output, DATA_SIZE x N, skewed row lanes to the array in_a.
REQ-009 SHALL have port out_b, output, DATA_SIZE x N, skewed column lanes to the array in_b.
REQ-010 SHALL have port array_clear, output, 1, synchronous clear pulse to the array's reset input.
REQ-011 SHALL have port busy, output, 1, high from accepted start until done.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when the array result is valid.

Function
REQ-013 SHALL implement FSM states IDLE, CLEAR, STREAM, DRAIN, DONE.
REQ-014 SHALL accept start only in IDLE; on acceptance capture mat_a/mat_b into internal registers, go to CLEAR, assert busy.
REQ-015 SHALL ignore start in every state other than IDLE; captured matrices SHALL not change while busy.
REQ-016 SHALL drive array_clear=1 for exactly the one CLEAR cycle, out_a/out_b all zero, then go to STREAM.
REQ-017 SHALL count t = 0..2N-2 in STREAM (one cycle each), then go to DRAIN.
REQ-018 SHALL drive in STREAM cycle t: out_a[i] = A[i][t-i] and out_b[j] = B[t-j][j] when 0 <= t-lane < N, else zero.
REQ-019 SHALL drive all lanes zero in DRAIN for exactly N cycles, then go to DONE.
REQ-020 SHALL assert done for the single DONE cycle, then return to IDLE with busy low; start is acceptable the following cycle.
REQ-021 SHALL register all outputs (no combinational path from start/mat_a/mat_b to outputs).
REQ-022 SHALL pass element values unmodified (no arithmetic, no truncation); counters SHALL be sized $clog2(2N) bits.
REQ-023 Total latency from accepted start edge to done high SHALL be 1 + (2N-1) + N cycles (N=3: 9).

Reset
REQ-024 SHALL on reset low, asynchronously: state IDLE, counters zero, out_a/out_b zero, array_clear 0, busy 0, done 0, captured matrices zero.
REQ-025 SHALL on reset mid-operation abort the transfer without a done pulse; first cycle after release SHALL be IDLE.

Configuration
REQ-026 SHALL support macro SKEW_FEEDER_B_TRANSPOSED_EN: defined -> mat_b is interpreted column-major (element r,c at index c*N+r); undefined -> row-major per REQ-007; timing identical.

Structure
REQ-027 SHALL place the state enum type and a function computing stream/drain lengths from N in package systolic_feeder_pkg.
REQ-028 SHALL use one sub-module skew_lane_select (lane index, t, captured row/column -> element or zero), instantiated 2N times.

Verification
REQ-029 A=[1 2 3;4 5 6;7 8 9], B=[2 1 3;4 5 7;6 9 8], start -> array_clear cycle, STREAM out_a {1,0,0},{2,4,0},{3,5,7},{0,6,8},{0,0,9}, out_b {2,0,0},{4,1,0},{6,5,3},{0,9,7},{0,0,8}; with matrix_multiply attached, out_matrix = [28 38 41;64 83 95;100 128 149] when done pulses.
REQ-030 start held high continuously -> second transfer begins the cycle after done; mat_a changed mid-stream -> no change in out_a.
REQ-031 reset low during STREAM t=2 -> all outputs zero immediately, no done, next start yields a full correct sequence.
REQ-032 N=4, A=identity, B=[1..16] -> lanes follow REQ-018, done 12 cycles after start, product equals B.
REQ-033 Build with SKEW_FEEDER_B_TRANSPOSED_EN, mat_b supplied as transpose of REQ-029 B -> identical out_b sequence.

Source files
------------

// File: rtl/systolic_feeder_pkg.sv
// rtl/systolic_feeder_pkg.sv - shared state type and sequence-length helpers for the skew feeder
package systolic_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_t;

  // Skewed wavefront of an N x N operand pair spans 2N-1 cycles.
  function automatic int stream_len(input int n);
    return 2 * n - 1;
  endfunction

  // Last products ripple through N more PE stages before the array result settles.
  function automatic int drain_len(input int n);
    return n;
  endfunction

endpackage

// File: rtl/skew_lane_select.sv
// rtl/skew_lane_select.sv - picks element t-LANE of one captured row/column, or zero outside the wavefront
module skew_lane_select #(
  parameter int DATA_SIZE = 1024,
  parameter int MATRIX_SIZE = 3,
  parameter int CW = 3,
  parameter int LANE = 0
) (
  input  logic                             active,
  input  logic [CW-1:0]                    t,
  input  logic [DATA_SIZE*MATRIX_SIZE-1:0] vec,
  output logic [DATA_SIZE-1:0]             elem
);

  always_comb begin
    elem = '0;
    for (int k = 0; k < MATRIX_SIZE; k++) begin
      if (active && (int'(t) == LANE + k)) begin
        elem = vec[k*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - streams a captured matrix pair into a systolic array as skewed lanes
// Optional macro SKEW_FEEDER_B_TRANSPOSED_EN: mat_b is taken column-major instead of row-major.
module systolic_skew_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int DATA_SIZE = 1024,
  parameter int MATRIX_SIZE = 3
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic [DATA_SIZE*MATRIX_SIZE*MATRIX_SIZE-1:0] mat_a,
  input  logic [DATA_SIZE*MATRIX_SIZE*MATRIX_SIZE-1:0] mat_b,
  output logic [DATA_SIZE*MATRIX_SIZE-1:0]             out_a,
  output logic [DATA_SIZE*MATRIX_SIZE-1:0]             out_b,
  output logic                                         array_clear,
  output logic                                         busy,
  output logic                                         done
);

  localparam int N  = MATRIX_SIZE;
  localparam int CW = $clog2(2 * N);
  localparam int ML = DATA_SIZE * N * N;
  localparam int LW = DATA_SIZE * N;
  localparam logic [CW-1:0] STREAM_LAST = CW'(stream_len(N) - 1);
  localparam logic [CW-1:0] DRAIN_LAST  = CW'(drain_len(N) - 1);

  feeder_state_t   state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            capture;
  logic [ML-1:0]   mat_a_q, mat_b_q;
  logic [LW-1:0]   a_nxt, b_nxt;
  logic            lanes_active;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CLEAR;
          capture   = 1'b1;
        end
      end
      CLEAR: begin
        state_nxt = STREAM;
        cnt_nxt   = '0;
      end
      STREAM: begin
        if (cnt == STREAM_LAST) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so they register in step with it.
  assign lanes_active = (state_nxt == STREAM);

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [LW-1:0] row_a;
    logic [LW-1:0] col_b;
    for (genvar k = 0; k < N; k++) begin : g_el
      assign row_a[k*DATA_SIZE +: DATA_SIZE] = mat_a_q[(i*N+k)*DATA_SIZE +: DATA_SIZE];
`ifdef SKEW_FEEDER_B_TRANSPOSED_EN
      assign col_b[k*DATA_SIZE +: DATA_SIZE] = mat_b_q[(i*N+k)*DATA_SIZE +: DATA_SIZE];
`else
      assign col_b[k*DATA_SIZE +: DATA_SIZE] = mat_b_q[(k*N+i)*DATA_SIZE +: DATA_SIZE];
`endif
    end

    skew_lane_select #(
      .DATA_SIZE(DATA_SIZE), .MATRIX_SIZE(N), .CW(CW), .LANE(i)
    ) u_sel_a (
      .active(lanes_active), .t(cnt_nxt), .vec(row_a),
      .elem(a_nxt[i*DATA_SIZE +: DATA_SIZE])
    );

    skew_lane_select #(
      .DATA_SIZE(DATA_SIZE), .MATRIX_SIZE(N), .CW(CW), .LANE(i)
    ) u_sel_b (
      .active(lanes_active), .t(cnt_nxt), .vec(col_b),
      .elem(b_nxt[i*DATA_SIZE +: DATA_SIZE])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      mat_a_q     <= '0;
      mat_b_q     <= '0;
      out_a       <= '0;
      out_b       <= '0;
      array_clear <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      if (capture) begin
        mat_a_q <= mat_a;
        mat_b_q <= mat_b;
      end
      out_a       <= a_nxt;
      out_b       <= b_nxt;
      array_clear <= (state_nxt == CLEAR);
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - scoreboard bench for systolic_skew_feeder with a matrix-level reference model
module tb_systolic_skew_feeder;

  localparam int DW = 16;
  localparam int N  = 3;
  localparam int ML = DW * N * N;
  localparam int LW = DW * N;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [ML-1:0] mat_a, mat_b;
  logic [LW-1:0] out_a, out_b;
  logic          array_clear, busy, done;

  systolic_skew_feeder #(.DATA_SIZE(DW), .MATRIX_SIZE(N)) dut (
    .clk(clk), .reset(rst_n), .start(start), .mat_a(mat_a), .mat_b(mat_b),
    .out_a(out_a), .out_b(out_b), .array_clear(array_clear), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [LW-1:0] a;
    logic [LW-1:0] b;
    logic          clr;
    logic          dn;
  } frame_t;

  frame_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int busy_left = 0;

  task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected per-cycle output frames of one transfer, derived from the matrices.
  task automatic push_txn(input logic [ML-1:0] ma, input logic [ML-1:0] mb);
    logic [DW-1:0] am [N][N];
    logic [DW-1:0] bm [N][N];
    frame_t f;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        am[r][c] = ma[(r*N+c)*DW +: DW];
`ifdef SKEW_FEEDER_B_TRANSPOSED_EN
        bm[r][c] = mb[(c*N+r)*DW +: DW];
`else
        bm[r][c] = mb[(r*N+c)*DW +: DW];
`endif
      end
    f = '0; f.clr = 1'b1; exp_q.push_back(f);
    for (int t = 0; t < 2*N-1; t++) begin
      f = '0;
      for (int l = 0; l < N; l++)
        if (t - l >= 0 && t - l < N) begin
          f.a[l*DW +: DW] = am[l][t-l];
          f.b[l*DW +: DW] = bm[t-l][l];
        end
      exp_q.push_back(f);
    end
    for (int d = 0; d < N; d++) begin
      f = '0; exp_q.push_back(f);
    end
    f = '0; f.dn = 1'b1; exp_q.push_back(f);
  endtask

  // Reference timing: a transfer occupies 3N+1 cycles after acceptance, then one idle cycle.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) busy_left = 0;
    else if (busy_left == 0 && start) begin
      push_txn(mat_a, mat_b);
      busy_left = 3*N + 1;
    end else if (busy_left > 0) busy_left--;
    #1;
  endtask

  function automatic logic [ML-1:0] rand_mat();
    logic [ML-1:0] m;
    for (int k = 0; k < N*N; k++) m[k*DW +: DW] = DW'($urandom);
    return m;
  endfunction

  task automatic load_directed();
    int av [9];
    int bv [9];
    av = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    bv = '{2, 1, 3, 4, 5, 7, 6, 9, 8};
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        mat_a[(r*N+c)*DW +: DW] = DW'(av[r*N+c]);
`ifdef SKEW_FEEDER_B_TRANSPOSED_EN
        mat_b[(c*N+r)*DW +: DW] = DW'(bv[r*N+c]);
`else
        mat_b[(r*N+c)*DW +: DW] = DW'(bv[r*N+c]);
`endif
      end
  endtask

  always @(negedge clk) begin
    frame_t f;
    if (busy) begin
      if (exp_q.size() == 0) begin
        check("busy_without_expected_frame", {{(LW-1){1'b0}}, busy}, '0);
      end else begin
        f = exp_q.pop_front();
        check("out_a", out_a, f.a);
        check("out_b", out_b, f.b);
        check("array_clear", {{(LW-1){1'b0}}, array_clear}, {{(LW-1){1'b0}}, f.clr});
        check("done", {{(LW-1){1'b0}}, done}, {{(LW-1){1'b0}}, f.dn});
      end
    end else begin
      check("idle_out_a", out_a, '0);
      check("idle_out_b", out_b, '0);
      check("idle_clear_done", {{(LW-2){1'b0}}, array_clear, done}, '0);
      check("idle_no_pending", {{(LW-1){1'b0}}, (exp_q.size() != 0)}, '0);
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mat_a = '0;
    mat_b = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Worked example pair, single start pulse.
    load_directed();
    start = 1'b1;
    tick();
    start = 1'b0;
    mat_a = rand_mat();
    repeat (14) tick();

    // Start held high with inputs churning every cycle.
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      mat_a = rand_mat();
      mat_b = rand_mat();
      tick();
    end
    start = 1'b0;
    repeat (14) tick();

    // Reset during STREAM t=2, then a full directed transfer.
    load_directed();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    load_directed();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();

    // Random start/matrix traffic.
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 3) == 0);
      mat_a = rand_mat();
      mat_b = rand_mat();
      tick();
    end
    start = 1'b0;
    repeat (14) tick();

    check("queue_drained", LW'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
